// File: rtl/wb_merge_queue_if.sv
// wb_merge_queue_if: execute-lane enqueue, register-file write ports and issue-side status of the writeback queue
interface wb_merge_queue_if #(
  parameter int XLEN = 32,
  parameter int DEPTH = 8
);
  logic in0_valid;
  logic [3:0] in0_num;
  logic [XLEN-1:0] in0_data;
  logic in1_valid;
  logic [3:0] in1_num;
  logic [XLEN-1:0] in1_data;
  logic in_ready;
  logic wb_stall;
  logic [3:0] rd1_num;
  logic [XLEN-1:0] rd1_data;
  logic [3:0] rd2_num;
  logic [XLEN-1:0] rd2_data;
  logic rd_we;
  logic [15:0] pending_mask;
  logic [$clog2(DEPTH):0] count;
  logic empty;
  modport master (
    output in0_valid, in0_num, in0_data, in1_valid, in1_num, in1_data, wb_stall,
    input in_ready, rd1_num, rd1_data, rd2_num, rd2_data, rd_we, pending_mask, count, empty
  );
  modport slave (
    input in0_valid, in0_num, in0_data, in1_valid, in1_num, in1_data, wb_stall,
    output in_ready, rd1_num, rd1_data, rd2_num, rd2_data, rd_we, pending_mask, count, empty
  );
endinterface

// File: rtl/wb_merge_queue.sv
// wb_merge_queue: two-in/two-out in-order writeback queue with same-register pair coalescing
module wb_merge_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  wb_merge_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0] num_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, h1;
  logic [AW:0] count_q, count_d;
  logic [1:0] n, enq;
  logic e0, e1, merge;
  logic [15:0] pm;
  assign bus.in_ready = count_q <= (AW+1)'(DEPTH-2);
  assign e0 = bus.in_ready & bus.in0_valid;
  assign e1 = bus.in_ready & bus.in1_valid;
  assign enq = {1'b0, e0} + {1'b0, e1};
  assign h1 = head_q + AW'(1);
  assign n = bus.wb_stall ? 2'd0 : count_q >= (AW+1)'(2) ? 2'd2 : count_q[1:0];
  assign merge = n == 2'd2 && num_q[head_q] == num_q[h1];
  // A merged pair writes the younger entry on both ports; a single write duplicates onto rd2
  assign bus.rd_we = n != 2'd0;
  assign bus.rd1_num = n == 2'd0 ? 4'd0 : merge ? num_q[h1] : num_q[head_q];
  assign bus.rd1_data = n == 2'd0 ? '0 : merge ? data_q[h1] : data_q[head_q];
  assign bus.rd2_num = n == 2'd0 ? 4'd0 : n == 2'd1 ? num_q[head_q] : num_q[h1];
  assign bus.rd2_data = n == 2'd0 ? '0 : n == 2'd1 ? data_q[head_q] : data_q[h1];
  assign head_d = head_q + AW'(n);
  assign tail_d = tail_q + AW'(enq);
  assign count_d = count_q + (AW+1)'(enq) - (AW+1)'(n);
  assign bus.count = count_q;
  assign bus.empty = count_q == '0;
  assign bus.pending_mask = pm;
  always_comb begin
    pm = '0;
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, AW'(AW'(i) - head_q)} < count_q) pm[num_q[i]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // Storage is not reset; reset only blocks the write so the dropped entry never becomes visible
  always_ff @(posedge clk) begin
    if (!rst && e0) begin
      num_q[tail_q] <= bus.in0_num;
      data_q[tail_q] <= bus.in0_data;
    end
    if (!rst && e1) begin
      num_q[e0 ? tail_q + AW'(1) : tail_q] <= bus.in1_num;
      data_q[e0 ? tail_q + AW'(1) : tail_q] <= bus.in1_data;
    end
  end
endmodule

// File: tb/tb_wb_merge_queue.sv
// tb_wb_merge_queue: directed checks of enqueue, pairwise drain, coalescing, backpressure, wrap and reset
module tb_wb_merge_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  typedef struct packed {
    logic [3:0] num;
    logic [31:0] data;
  } ent_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  wb_merge_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  wb_merge_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic lanes(input logic v0, input logic [3:0] n0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] n1, input logic [31:0] d1);
    bus.in0_valid = v0;
    bus.in0_num = n0;
    bus.in0_data = d0;
    bus.in1_valid = v1;
    bus.in1_num = n1;
    bus.in1_data = d1;
  endtask
  initial begin
    ent_t q[$];
    int idx, cyc, sz, nn;
    logic [15:0] epm;
    logic [3:0] a0, a1;
    rst = 1'b1;
    bus.wb_stall = 1'b0;
    lanes(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_count", bus.count, 0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_ready", bus.in_ready, 1);
    chk("reset_we", bus.rd_we, 0);
    chk("reset_pm", bus.pending_mask, 0);
    // single write
    lanes(1, 3, 32'hDEADBEEF, 0, 0, 0);
    @(negedge clk);
    lanes(0, 0, 0, 0, 0, 0);
    chk("t1_we", bus.rd_we, 1);
    chk("t1_rd1", {bus.rd1_num, bus.rd1_data}, {4'd3, 32'hDEADBEEF});
    chk("t1_rd2", {bus.rd2_num, bus.rd2_data}, {4'd3, 32'hDEADBEEF});
    chk("t1_pm", bus.pending_mask, 16'h0008);
    chk("t1_count", bus.count, 1);
    @(negedge clk);
    chk("t1_empty", bus.empty, 1);
    chk("t1_we_off", bus.rd_we, 0);
    chk("t1_pm_off", bus.pending_mask, 0);
    chk("t1_rd1_zero", {bus.rd1_num, bus.rd1_data}, 0);
    // pair write
    lanes(1, 5, 32'h11, 1, 6, 32'h22);
    @(negedge clk);
    lanes(0, 0, 0, 0, 0, 0);
    chk("t2_rd1", {bus.rd1_num, bus.rd1_data}, {4'd5, 32'h11});
    chk("t2_rd2", {bus.rd2_num, bus.rd2_data}, {4'd6, 32'h22});
    chk("t2_pm", bus.pending_mask, 16'h0060);
    chk("t2_count", bus.count, 2);
    @(negedge clk);
    chk("t2_count_after", bus.count, 0);
    // coalesce
    lanes(1, 7, 32'hAA, 1, 7, 32'hBB);
    @(negedge clk);
    lanes(0, 0, 0, 0, 0, 0);
    chk("t3_we", bus.rd_we, 1);
    chk("t3_rd1", {bus.rd1_num, bus.rd1_data}, {4'd7, 32'hBB});
    chk("t3_rd2", {bus.rd2_num, bus.rd2_data}, {4'd7, 32'hBB});
    chk("t3_count", bus.count, 2);
    chk("t3_pm", bus.pending_mask, 16'h0080);
    @(negedge clk);
    chk("t3_count_after", bus.count, 0);
    // fill under stall
    bus.wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_ready_fill", bus.in_ready, 1);
      chk("t4_count_fill", bus.count, 2 * k);
      lanes(1, 4'(2 * k), 32'h100 + 2 * k, 1, 4'(2 * k + 1), 32'h101 + 2 * k);
      @(negedge clk);
    end
    lanes(1, 8, 32'h108, 1, 9, 32'h109);
    chk("t4_full_count", bus.count, 8);
    chk("t4_full_ready", bus.in_ready, 0);
    chk("t4_full_we", bus.rd_we, 0);
    chk("t4_full_pm", bus.pending_mask, 16'h00FF);
    @(negedge clk);
    chk("t4_held_count", bus.count, 8);
    chk("t4_held_pm", bus.pending_mask, 16'h00FF);
    bus.wb_stall = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j == 2) lanes(0, 0, 0, 0, 0, 0);
      #1;
      chk("t4_drain_we", bus.rd_we, 1);
      chk("t4_drain_rd1", {bus.rd1_num, bus.rd1_data}, {4'(2 * j), 32'h100 + 2 * j});
      chk("t4_drain_rd2", {bus.rd2_num, bus.rd2_data}, {4'(2 * j + 1), 32'h101 + 2 * j});
      chk("t4_drain_count", bus.count, j == 0 ? 8 : j == 1 ? 6 : j == 2 ? 6 : j == 3 ? 4 : 2);
      chk("t4_drain_ready", bus.in_ready, j == 0 ? 0 : 1);
      @(negedge clk);
    end
    chk("t4_drained", bus.count, 0);
    // wrap with alternating stall against a queue model
    idx = 0;
    cyc = 0;
    while ((idx < 20 || q.size() != 0) && cyc < 200) begin
      bus.wb_stall = cyc[0];
      a0 = 4'(idx * 3);
      a1 = 4'(idx * 3 + 1);
      if (idx < 20) lanes(1, a0, 32'h5000 + 2 * idx, 1, a1, 32'h5001 + 2 * idx);
      else lanes(0, 0, 0, 0, 0, 0);
      #1;
      sz = q.size();
      nn = bus.wb_stall ? 0 : (sz >= 2 ? 2 : sz);
      epm = '0;
      foreach (q[i]) epm[q[i].num] = 1'b1;
      chk("t5_count", bus.count, sz);
      chk("t5_bound", bus.count <= DEPTH, 1);
      chk("t5_ready", bus.in_ready, sz <= DEPTH - 2);
      chk("t5_pm", bus.pending_mask, epm);
      chk("t5_we", bus.rd_we, nn != 0);
      if (nn != 0) begin
        chk("t5_rd1", {bus.rd1_num, bus.rd1_data}, q[0]);
        chk("t5_rd2", {bus.rd2_num, bus.rd2_data}, nn == 1 ? q[0] : q[1]);
      end
      for (int p = 0; p < nn; p++) void'(q.pop_front());
      if (sz <= DEPTH - 2 && idx < 20) begin
        q.push_back({a0, 32'h5000 + 2 * idx});
        q.push_back({a1, 32'h5001 + 2 * idx});
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("t5_finished_in_budget", cyc < 200, 1);
    chk("t5_empty", bus.empty, 1);
    // reset mid-operation
    bus.wb_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      lanes(1, 4'(10 + k), 32'h900 + k, 0, 0, 0);
      @(negedge clk);
    end
    chk("t6_count5", bus.count, 5);
    chk("t6_pm5", bus.pending_mask, 16'h7C00);
    rst = 1'b1;
    lanes(1, 15, 32'hF00D, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.wb_stall = 1'b0;
    lanes(0, 0, 0, 0, 0, 0);
    #1;
    chk("t6_count", bus.count, 0);
    chk("t6_empty", bus.empty, 1);
    chk("t6_pm", bus.pending_mask, 0);
    chk("t6_we", bus.rd_we, 0);
    chk("t6_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("t6_never_written", bus.rd_we, 0);
    chk("t6_count_still", bus.count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
